iq_dispatch_ctrl: RTL and testbench

//  Dispatch controller for the IR-stage instruction queue. Each cycle it decides how many

---
 rtl/iq_dispatch_ctrl.sv | 141 ++++++++++++++
 tb/tb_iq_dispatch_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/iq_dispatch_ctrl.sv
// Instruction-queue dispatch controller: decides 0/1/2 head pops per cycle and owns post-flush recovery.
// Optional perf counters are enabled by defining IQ_DISPATCH_PERF_EN.
`default_nettype none

module iq_dispatch_ctrl #(
  parameter int IQ_ENTRIES        = 8,
  parameter int ROB_ENTRIES       = 64,
  parameter int FREE_W            = 7,
  parameter int FLUSH_HOLD_CYCLES = 2,
  localparam int IQ_W  = $clog2(IQ_ENTRIES) + 1,
  localparam int ROB_W = $clog2(ROB_ENTRIES) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              recovery_done_i,
  input  logic              stall_i,
  input  logic [IQ_W-1:0]   iq_num_i,
  input  logic              instr1_serial_i,
  input  logic              instr2_serial_i,
  input  logic              instr1_rd_i,
  input  logic              instr2_rd_i,
  input  logic [FREE_W-1:0] free_regs_i,
  input  logic [ROB_W-1:0]  rob_free_i,
  input  logic              rob_empty_i,
  output logic              read_head_o,
  output logic              issue_1_o,
  output logic              issue_2_o,
`ifdef IQ_DISPATCH_PERF_EN
  output logic [1:0]        ctrl_state_o,
  output logic [31:0]       perf_stall_cycles_o,
  output logic [31:0]       perf_dual_cycles_o
`else
  output logic [1:0]        ctrl_state_o
`endif
);

  localparam int HOLD_W = (FLUSH_HOLD_CYCLES < 1) ? 1 : $clog2(FLUSH_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FLUSH_HOLD_CYCLES);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SER_DRAIN = 2'd1,
    SER_WAIT  = 2'd2,
    RECOVER   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              done_latch, done_latch_nxt;
  logic              ok1, dual_ok, issue1, issue2;
  logic [FREE_W-1:0] rd_sum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= RECOVER;
      hold_cnt   <= HOLD_LOAD;
      done_latch <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      done_latch <= done_latch_nxt;
    end
  end

  always_comb begin
    ok1 = !stall_i && (iq_num_i >= IQ_W'(1)) && (rob_free_i >= ROB_W'(1))
          && (!instr1_rd_i || (free_regs_i >= FREE_W'(1)));
    rd_sum  = FREE_W'(instr1_rd_i) + FREE_W'(instr2_rd_i);
    dual_ok = !instr1_serial_i && !instr2_serial_i && (iq_num_i >= IQ_W'(2))
              && (rob_free_i >= ROB_W'(2)) && (free_regs_i >= rd_sum);
  end

  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    done_latch_nxt = done_latch;
    issue1         = 1'b0;
    issue2         = 1'b0;
    if (flush_i) begin
      state_nxt      = RECOVER;
      hold_cnt_nxt   = HOLD_LOAD;
      done_latch_nxt = 1'b0;
    end else begin
      case (state)
        RECOVER: begin
          hold_cnt_nxt   = (hold_cnt == '0) ? '0 : hold_cnt - HOLD_W'(1);
          done_latch_nxt = done_latch | recovery_done_i;
          // Exit once the count has expired this cycle, so the hold lasts exactly FLUSH_HOLD_CYCLES.
          if ((hold_cnt_nxt == '0) && (done_latch || recovery_done_i)) begin
            state_nxt      = RUN;
            done_latch_nxt = 1'b0;
          end
        end
        RUN: begin
          if (instr1_serial_i) begin
            if (ok1 && rob_empty_i) begin
              issue1    = 1'b1;
              state_nxt = SER_WAIT;
            end else begin
              state_nxt = SER_DRAIN;
            end
          end else begin
            issue1 = ok1;
            issue2 = ok1 && dual_ok;
          end
        end
        SER_DRAIN: begin
          if (rob_empty_i && ok1) begin
            issue1    = 1'b1;
            state_nxt = SER_WAIT;
          end
        end
        SER_WAIT: begin
          if (rob_empty_i) state_nxt = RUN;
        end
        default: state_nxt = RECOVER;
      endcase
    end
  end

  assign issue_1_o    = issue1;
  assign issue_2_o    = issue2;
  assign read_head_o  = issue1;
  assign ctrl_state_o = state;

`ifdef IQ_DISPATCH_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_cycles_o <= '0;
      perf_dual_cycles_o  <= '0;
    end else begin
      if ((iq_num_i != '0) && !issue1) perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
      if (issue2)                      perf_dual_cycles_o  <= perf_dual_cycles_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_iq_dispatch_ctrl.sv
// Scoreboard bench for iq_dispatch_ctrl; directed vectors with hand-computed expectations.
`default_nettype none
`timescale 1ns/1ps

module tb_iq_dispatch_ctrl;

  localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_WAIT = 2'd2, S_REC = 2'd3;

  logic       clk = 1'b0;
  logic       rst, flush, done, stall, s1, s2, r1, r2, robe;
  logic [3:0] iq;
  logic [6:0] fr, rf;
  logic       read_head, issue_1, issue_2;
  logic [1:0] st;
`ifdef IQ_DISPATCH_PERF_EN
  logic [31:0] perf_stall, perf_dual;
`endif

  always #5 clk = ~clk;

  iq_dispatch_ctrl dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .recovery_done_i(done), .stall_i(stall),
    .iq_num_i(iq), .instr1_serial_i(s1), .instr2_serial_i(s2), .instr1_rd_i(r1),
    .instr2_rd_i(r2), .free_regs_i(fr), .rob_free_i(rf), .rob_empty_i(robe),
    .read_head_o(read_head), .issue_1_o(issue_1), .issue_2_o(issue_2),
`ifdef IQ_DISPATCH_PERF_EN
    .ctrl_state_o(st), .perf_stall_cycles_o(perf_stall), .perf_dual_cycles_o(perf_dual)
`else
    .ctrl_state_o(st)
`endif
  );

  typedef struct {
    string      name;
    logic       i1;
    logic       i2;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      m_e = sb.pop_front();
      checks++;
      if ({issue_1, issue_2, st} !== {m_e.i1, m_e.i2, m_e.st}) begin
        errors++;
        $display("FAIL %s: got i1=%0b i2=%0b state=%0d, expected i1=%0b i2=%0b state=%0d",
                 m_e.name, issue_1, issue_2, st, m_e.i1, m_e.i2, m_e.st);
      end
      checks++;
      if (read_head !== m_e.i1) begin
        errors++;
        $display("FAIL %s read_head: got %0b expected %0b", m_e.name, read_head, m_e.i1);
      end
    end
  end

  // Drive one cycle of inputs at posedge+1, push the expectation, advance to the next posedge+1.
  task automatic vec(input string name, input logic fl, input logic dn, input logic sl,
                     input logic [3:0] n, input logic a1, input logic a2, input logic d1,
                     input logic d2, input logic [6:0] free, input logic [6:0] robf,
                     input logic empty, input logic e1, input logic e2, input logic [1:0] es);
    exp_t e;
    flush = fl; done = dn; stall = sl; iq = n; s1 = a1; s2 = a2; r1 = d1; r2 = d2;
    fr = free; rf = robf; robe = empty;
    e.name = name; e.i1 = e1; e.i2 = e2; e.st = es;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

`ifdef IQ_DISPATCH_PERF_EN
  task automatic chk_perf(input string name, input int es, input int ed);
    checks++;
    if (perf_stall !== 32'(es) || perf_dual !== 32'(ed)) begin
      errors++;
      $display("FAIL %s: got stall=%0d dual=%0d expected stall=%0d dual=%0d",
               name, perf_stall, perf_dual, es, ed);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 0; done = 0; stall = 0; iq = 4'd4; s1 = 0; s2 = 0; r1 = 0; r2 = 0;
    fr = 7'd20; rf = 7'd30; robe = 0;
    @(posedge clk); #1;
    //    name            fl dn sl iq  s1 s2 r1 r2 free robf re  i1 i2 state
    vec("in_reset",       0, 1, 0, 4, 0, 0, 1, 1, 20, 30, 0, 0, 0, S_REC);
    rst = 1'b0;
    vec("recover_c1",     0, 1, 0, 4, 0, 0, 1, 1, 20, 30, 0, 0, 0, S_REC);
    vec("recover_c2",     0, 1, 0, 4, 0, 0, 1, 1, 20, 30, 0, 0, 0, S_REC);
    vec("run_dual",       0, 0, 0, 4, 0, 0, 1, 1, 20, 30, 0, 1, 1, S_RUN);
    vec("serial2_single", 0, 0, 0, 3, 0, 1, 1, 1, 20, 30, 0, 1, 0, S_RUN);
    vec("serial1_block",  0, 0, 0, 3, 1, 0, 1, 1, 20, 30, 0, 0, 0, S_RUN);
    vec("drain_wait",     0, 0, 0, 3, 1, 0, 1, 1, 20, 30, 0, 0, 0, S_DRAIN);
    vec("drain_issue",    0, 0, 0, 3, 1, 0, 1, 1, 20, 30, 1, 1, 0, S_DRAIN);
    vec("ser_wait_busy",  0, 0, 0, 3, 0, 0, 1, 1, 20, 30, 0, 0, 0, S_WAIT);
    vec("ser_wait_exit",  0, 0, 0, 3, 0, 0, 1, 1, 20, 30, 1, 0, 0, S_WAIT);
    vec("free1_rd2",      0, 0, 0, 3, 0, 0, 1, 1, 1,  30, 0, 1, 0, S_RUN);
    vec("free0_rd1",      0, 0, 0, 3, 0, 0, 1, 0, 0,  30, 0, 0, 0, S_RUN);
    vec("robfree1",       0, 0, 0, 3, 0, 0, 1, 1, 20, 1,  0, 1, 0, S_RUN);
    vec("free2_rd2",      0, 0, 0, 3, 0, 0, 1, 1, 2,  30, 0, 1, 1, S_RUN);
    vec("free0_nord",     0, 0, 0, 3, 0, 0, 0, 0, 0,  30, 0, 1, 1, S_RUN);
    vec("stalled",        0, 0, 1, 3, 0, 0, 1, 1, 20, 30, 0, 0, 0, S_RUN);
    vec("serial_empty",   0, 0, 0, 5, 1, 0, 1, 1, 20, 30, 1, 1, 0, S_RUN);
    vec("flush_in_wait",  1, 0, 0, 5, 0, 0, 1, 1, 20, 30, 1, 0, 0, S_WAIT);
    vec("rec_a1",         0, 1, 0, 5, 0, 0, 1, 1, 20, 30, 0, 0, 0, S_REC);
    vec("flush_in_rec",   1, 0, 0, 5, 0, 0, 1, 1, 20, 30, 0, 0, 0, S_REC);
    vec("rec_b1",         0, 1, 0, 5, 0, 0, 1, 1, 20, 30, 0, 0, 0, S_REC);
    vec("rec_b2_latch",   0, 0, 0, 5, 0, 0, 1, 1, 20, 30, 0, 0, 0, S_REC);
    vec("post_recover",   0, 0, 0, 5, 0, 0, 1, 1, 20, 30, 0, 1, 1, S_RUN);
    vec("iq1_garbage2",   0, 0, 0, 1, 0, 1, 0, 1, 20, 30, 0, 1, 0, S_RUN);
    vec("iq0",            0, 0, 0, 0, 0, 1, 1, 1, 20, 30, 1, 0, 0, S_RUN);
    vec("iq0_serial",     0, 0, 0, 0, 1, 0, 1, 1, 20, 30, 1, 0, 0, S_RUN);
    vec("iq0_drain",      0, 0, 0, 0, 1, 0, 1, 1, 20, 30, 1, 0, 0, S_DRAIN);
    vec("drain_refill",   0, 0, 0, 2, 1, 0, 1, 1, 20, 30, 1, 1, 0, S_DRAIN);

`ifdef IQ_DISPATCH_PERF_EN
    rst = 1'b1;
    @(posedge clk); #1;
    chk_perf("perf_reset", 0, 0);
    rst = 1'b0;
    vec("perf_rec1",      0, 1, 0, 0, 0, 0, 0, 0, 20, 30, 0, 0, 0, S_REC);
    vec("perf_rec2",      0, 1, 0, 0, 0, 0, 0, 0, 20, 30, 0, 0, 0, S_REC);
    for (int i = 0; i < 10; i++)
      vec("perf_stall",   0, 0, 1, 3, 0, 0, 0, 0, 20, 30, 0, 0, 0, S_RUN);
    for (int i = 0; i < 4; i++)
      vec("perf_dual",    0, 0, 0, 4, 0, 0, 0, 0, 20, 30, 0, 1, 1, S_RUN);
    chk_perf("perf_counts", 10, 4);
    vec("perf_flush",     1, 0, 0, 0, 0, 0, 0, 0, 20, 30, 0, 0, 0, S_RUN);
    chk_perf("perf_after_flush", 10, 4);
    rst = 1'b1;
    #2;
    chk_perf("perf_after_rst", 0, 0);
    rst = 1'b0;
`endif

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d expectations left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
